// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU issue/writeback sequencer.
// Opcode values match the ALU opALU encoding.
package alu_op_sequencer_pkg;

  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int DW   = 16;

  localparam logic [1:0] OP_XOR = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_SUB = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction issue handshake between the front end and the sequencer.
// Transfer happens on a clock edge where instr_valid and instr_ready are both high.
interface alu_op_sequencer_if #(
  parameter int AW = 3
);

  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs;
  logic [AW-1:0] instr_rt;

  modport master (
    output instr_valid,
    output instr_op,
    output instr_rd,
    output instr_rs,
    output instr_rt,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_op,
    input  instr_rd,
    input  instr_rs,
    input  instr_rt,
    output instr_ready
  );

endinterface

// File: rtl/alu_op_sequencer_regfile.sv
// NREG x 16 register file: operand and debug async reads, sync writes.
// Writeback and direct load may land together; on an address clash writeback wins.
module seq_regfile #(
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [15:0]   rs_data,
  output logic [15:0]   rt_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [15:0]   dbg_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [15:0]   wb_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [15:0]   ld_data
);

  logic [15:0] rf [NREG];

  logic ld_ok;

  assign ld_ok = ld_en && !(wb_en && (wb_addr == ld_addr));

  assign rs_data  = rf[rs_addr];
  assign rt_data  = rf[rt_addr];
  assign dbg_data = rf[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (ld_ok) begin
        rf[ld_addr] <= ld_data;
      end
      if (wb_en) begin
        rf[wb_addr] <= wb_data;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Non-pipelined issue/writeback sequencer for the 16-bit ALU.
// One instruction in flight: IDLE -> EXEC (ALU_LAT cycles) -> WB.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int NREG    = 8,
  parameter int AW      = 3,
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   instr,
  input  logic                ld_en,
  input  logic [AW-1:0]       ld_addr,
  input  logic [15:0]         ld_data,
  output logic [15:0]         alu_a,
  output logic [15:0]         alu_b,
  output logic [1:0]          alu_op,
  input  logic [16:0]         alu_r,
  output logic                wb_valid,
  output logic [AW-1:0]       wb_addr,
  output logic [15:0]         wb_data,
  output logic                flag_c,
  input  logic [AW-1:0]       dbg_addr,
  output logic [15:0]         dbg_data
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);

  state_t        state;
  logic          ready_q;
  logic [CW-1:0] cnt;
  logic [AW-1:0] rd_q;
  logic [16:0]   res_q;
  logic [15:0]   rs_data;
  logic [15:0]   rt_data;
  logic          rf_wb_en;

  assign instr.instr_ready = ready_q;
  assign rf_wb_en = (state == S_WB);

  seq_regfile #(
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (instr.instr_rs),
    .rt_addr  (instr.instr_rt),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wb_en    (rf_wb_en),
    .wb_addr  (rd_q),
    .wb_data  (res_q[15:0]),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ready_q  <= 1'b1;
      cnt      <= '0;
      rd_q     <= '0;
      res_q    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      flag_c   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (instr.instr_valid) begin
            alu_a   <= rs_data;
            alu_b   <= rt_data;
            alu_op  <= instr.instr_op;
            rd_q    <= instr.instr_rd;
            cnt     <= CNT_INIT;
            ready_q <= 1'b0;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
            res_q    <= alu_r;
            wb_valid <= 1'b1;
            wb_addr  <= rd_q;
            wb_data  <= alu_r[15:0];
            state    <= S_WB;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WB: begin
          // rf write of res_q happens on this same edge
          flag_c  <= res_q[16];
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
